// File: rtl/post_processing_pkg.sv
// Shared divider definitions: post-processing FSM encoding, datapath widths and
// the normalization shift base used by both the pre- and post-processing stages.
package post_processing_pkg;

  localparam int DIV_DW    = 32;
  localparam int REM_W     = DIV_DW + 6;
  localparam int DIVS_W    = DIV_DW + 3;
  localparam int NORM_BASE = DIV_DW + 1;
  localparam int SHAMT_W   = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESOLVE = 3'd1,
    ST_CORRECT = 3'd2,
    ST_DENORM  = 3'd3,
    ST_SIGN    = 3'd4,
    ST_DONE    = 3'd5
  } pp_state_e;

  // Right-shift amount that undoes the pre-processing normalization.
  function automatic logic [SHAMT_W-1:0] denorm_amount(input logic [SHAMT_W-1:0] recovery);
    return SHAMT_W'(NORM_BASE) - recovery;
  endfunction

endpackage

// File: rtl/rem_denorm_shifter.sv
// Combinational logical right barrel shifter: REM_W-bit remainder down to a
// DIV_DW-bit result, one log stage per bit of the shift amount.
module rem_denorm_shifter
  import post_processing_pkg::*;
(
  input  logic [REM_W-1:0]   val_i,
  input  logic [SHAMT_W-1:0] amt_i,
  output logic [DIV_DW-1:0]  res_o
);

  logic [REM_W-1:0] stage;

  always_comb begin
    stage = val_i;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (amt_i[k]) stage = stage >> (1 << k);
    end
    res_o = stage[DIV_DW-1:0];
  end

endmodule

// File: rtl/post_processing.sv
// Divider back end: resolves the carry-save remainder, applies the one-step
// correction, denormalizes, applies sign fixups and hands the result to writeback.
module post_processing
  import post_processing_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REM_W-1:0]    rem_sum,
  input  logic [REM_W-1:0]    rem_carry,
  input  logic [DW-1:0]       q,
  input  logic [DW-1:0]       qm,
  input  logic [DIVS_W-1:0]   divisor_star,
  input  logic [DW/2-1:0]     recovery,
  input  logic                div_zero,
  input  logic [DW-1:0]       dividend_raw,
  input  logic                quot_neg,
  input  logic                rem_neg,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       quotient,
  output logic [DW-1:0]       remainder
);

  function automatic logic [DW-1:0] negate_if(input logic [DW-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  pp_state_e state_q, state_d;
  logic in_ready_q, out_valid_q;
  logic [DW-1:0] quot_q, quot_d, rem_q, rem_d;
  logic signed [REM_W-1:0] r_q, r_d;

  logic signed [REM_W-1:0] sum_q, carry_q;
  logic [DW-1:0]           opq_q, opqm_q;
  logic [DIVS_W-1:0]       divs_q;
  logic [SHAMT_W-1:0]      rec_q;
  logic                    qneg_q, rneg_q;

  logic              accept;
  logic [DW-1:0]     denorm_res;
  logic              unused_rec_hi;

  // recovery never exceeds 31, so only its low bits carry information.
  assign unused_rec_hi = |recovery[DW/2-1:SHAMT_W];

  assign accept = (state_q == ST_IDLE) && in_valid;

  rem_denorm_shifter u_shifter (
    .val_i (r_q),
    .amt_i (denorm_amount(rec_q)),
    .res_o (denorm_res)
  );

  always_comb begin
    state_d = state_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    r_d     = r_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (div_zero) begin
            quot_d  = '1;
            rem_d   = negate_if(dividend_raw, rem_neg);
            state_d = ST_DONE;
          end else begin
            state_d = ST_RESOLVE;
          end
        end
      end
      ST_RESOLVE: begin
        r_d     = sum_q + carry_q;
        state_d = ST_CORRECT;
      end
      ST_CORRECT: begin
        // Negative remainder means the last quotient digit overshot by one.
        if (r_q[REM_W-1]) begin
          r_d    = r_q + $signed({{(REM_W-DIVS_W){1'b0}}, divs_q});
          quot_d = opqm_q;
        end else begin
          quot_d = opq_q;
        end
        state_d = ST_DENORM;
      end
      ST_DENORM: begin
        rem_d   = denorm_res;
        state_d = ST_SIGN;
      end
      ST_SIGN: begin
        quot_d  = negate_if(quot_q, qneg_q);
        rem_d   = negate_if(rem_q, rneg_q);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      quot_q      <= quot_d;
      rem_q       <= rem_d;
    end
  end

  // Operand capture and working remainder carry no reset; they are only
  // consumed after an acceptance has loaded them.
  always_ff @(posedge clk) begin
    r_q <= r_d;
    if (accept) begin
      sum_q   <= rem_sum;
      carry_q <= rem_carry;
      opq_q   <= q;
      opqm_q  <= qm;
      divs_q  <= divisor_star;
      rec_q   <= recovery[SHAMT_W-1:0];
      qneg_q  <= quot_neg;
      rneg_q  <= rem_neg;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_post_processing.sv
// Self-checking bench for post_processing: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_post_processing;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        div_zero = 1'b0;
  logic        quot_neg = 1'b0;
  logic        rem_neg = 1'b0;
  logic [37:0] rem_sum = '0;
  logic [37:0] rem_carry = '0;
  logic [31:0] q = '0;
  logic [31:0] qm = '0;
  logic [31:0] dividend_raw = '0;
  logic [34:0] divisor_star = '0;
  logic [15:0] recovery = '0;
  logic        in_ready, out_valid;
  logic [31:0] quotient, remainder;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;

  post_processing #(.DW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rem_sum      (rem_sum),
    .rem_carry    (rem_carry),
    .q            (q),
    .qm           (qm),
    .divisor_star (divisor_star),
    .recovery     (recovery),
    .div_zero     (div_zero),
    .dividend_raw (dividend_raw),
    .quot_neg     (quot_neg),
    .rem_neg      (rem_neg),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference: remainder taken modulo 2^38, sign decided by magnitude vs 2^37.
  function automatic void ref_model(
    input  logic [37:0] s, c,
    input  logic [31:0] qv, qmv,
    input  logic [34:0] d,
    input  int          rec,
    input  bit          dz,
    input  logic [31:0] draw,
    input  bit          qn, rn,
    output logic [31:0] eq, er);
    longint unsigned m, r, su, cu, du;
    m  = 64'd1 << 38;
    su = s; cu = c; du = d;
    if (dz) begin
      eq = 32'hFFFF_FFFF;
      er = draw;
      if (rn) er = 32'd0 - draw;
    end else begin
      r = (su + cu) % m;
      if (r >= m / 2) begin
        r  = (r + du) % m;
        eq = qmv;
      end else begin
        eq = qv;
      end
      er = 32'(r >> (33 - rec));
      if (qn) eq = 32'd0 - eq;
      if (rn) er = 32'd0 - er;
    end
  endfunction

  task automatic set_op(input logic [37:0] s, c, input logic [31:0] qq, qqm,
                        input logic [34:0] d, input int rec, input bit dz,
                        input logic [31:0] draw, input bit qn, rn);
    rem_sum = s; rem_carry = c; q = qq; qm = qqm; divisor_star = d;
    recovery = 16'(rec); div_zero = dz; dividend_raw = draw;
    quot_neg = qn; rem_neg = rn;
  endtask

  task automatic send_op();
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL in_ready_wait: got in_ready=%b, required 1", in_ready);
    end
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (quotient !== 32'd0) begin bad++; $display("FAIL reset_quotient: got %h want 0", quotient); end
    total++; if (remainder !== 32'd0) begin bad++; $display("FAIL reset_remainder: got %h want 0", remainder); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_positive();
    int lat;
    set_op(38'd2 << 31, '0, 32'd14, 32'd13, 35'd7 << 31, 2, 0, '0, 0, 0);
    send_op();
    wait_valid(lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL pos_latency: got %0d want 5", lat); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL pos_quotient: got %0d want 14", quotient); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL pos_remainder: got %0d want 2", remainder); end
    finish_op();
  endtask

  task automatic test_correction();
    int lat;
    longint v;
    logic [63:0] t;
    v = -5;
    v = v <<< 31;
    t = v;
    set_op(t[37:0], '0, 32'd15, 32'd14, 35'd7 << 31, 2, 0, '0, 0, 0);
    send_op();
    wait_valid(lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL corr_latency: got %0d want 5", lat); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL corr_quotient: got %0d want 14", quotient); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL corr_remainder: got %0d want 2", remainder); end
    finish_op();
  endtask

  task automatic test_div_zero();
    int lat;
    set_op('0, '0, 32'd5, 32'd4, '0, 7, 1, 32'h1234, 1, 0);
    send_op();
    wait_valid(lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency: got %0d want 1", lat); end
    total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_quotient: got %h want ffffffff", quotient); end
    total++; if (remainder !== 32'h1234) begin bad++; $display("FAIL dz_remainder: got %h want 1234", remainder); end
    finish_op();
    set_op('0, '0, 32'd5, 32'd4, '0, 7, 1, 32'h1234, 0, 1);
    send_op();
    wait_valid(lat);
    total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dzneg_quotient: got %h want ffffffff", quotient); end
    total++; if (remainder !== 32'hFFFF_EDCC) begin bad++; $display("FAIL dzneg_remainder: got %h want ffffedcc", remainder); end
    finish_op();
  endtask

  task automatic test_signed();
    int lat;
    set_op(38'd1 << 31, '0, 32'd3, 32'd2, 35'd2 << 31, 2, 0, '0, 1, 1);
    send_op();
    wait_valid(lat);
    total++; if (quotient !== 32'hFFFF_FFFD) begin bad++; $display("FAIL signed_quotient: got %h want fffffffd", quotient); end
    total++; if (remainder !== 32'hFFFF_FFFF) begin bad++; $display("FAIL signed_remainder: got %h want ffffffff", remainder); end
    finish_op();
  endtask

  task automatic test_backpressure_reset();
    int lat;
    int errs;
    set_op(38'd2 << 31, '0, 32'd14, 32'd13, 35'd7 << 31, 2, 0, '0, 0, 0);
    send_op();
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      set_op(38'd9 << 31, 38'd1, 32'hABCD, 32'hABCC, 35'd3 << 31, 5, (i % 2) == 1, 32'h55, 1, 1);
      in_valid = 1'b1;
      @(negedge clk);
      errs = 0;
      if (out_valid !== 1'b1) errs++;
      if (in_ready !== 1'b0) errs++;
      if (quotient !== 32'd14) errs++;
      if (remainder !== 32'd2) errs++;
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL stall_hold cycle %0d: got valid=%b ready=%b q=%0d r=%0d want valid=1 ready=0 q=14 r=2",
                 i, out_valid, in_ready, quotient, remainder);
      end
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
    total++; if (quotient !== 32'd0 || remainder !== 32'd0) begin
      bad++; $display("FAIL rst_mid_outputs: got q=%h r=%h want 0 0", quotient, remainder);
    end
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_no_pulse: got %b want 0", out_valid); end
  endtask

  task automatic test_boundary();
    int lat;
    set_op(38'd5 << 2, '0, 32'd9, 32'd8, 35'd3 << 2, 31, 0, '0, 0, 0);
    send_op();
    wait_valid(lat);
    total++; if (quotient !== 32'd9 || remainder !== 32'd5) begin
      bad++; $display("FAIL rec31: got q=%0d r=%0d want q=9 r=5", quotient, remainder);
    end
    finish_op();
    set_op('0, '0, 32'd123, 32'd122, 35'd1 << 33, 0, 0, '0, 0, 0);
    send_op();
    wait_valid(lat);
    total++; if (quotient !== 32'd123 || remainder !== 32'd0) begin
      bad++; $display("FAIL rec0_zero: got q=%0d r=%0d want q=123 r=0", quotient, remainder);
    end
    finish_op();
    set_op(38'd3 << 33, '0, 32'd77, 32'd76, 35'd1 << 33, 0, 0, '0, 0, 0);
    send_op();
    wait_valid(lat);
    total++; if (remainder !== 32'd3) begin bad++; $display("FAIL rec0_three: got r=%0d want 3", remainder); end
    finish_op();
  endtask

  task automatic test_random();
    int lat, rec;
    bit dz, qn, rn;
    logic [63:0] ts, tc, td;
    logic [31:0] rq, rqm, draw, eq, er;
    for (int n = 0; n < 25; n++) begin
      ts = {$urandom(), $urandom()};
      tc = {$urandom(), $urandom()};
      td = {$urandom(), $urandom()};
      rq = $urandom(); rqm = $urandom(); draw = $urandom();
      rec = int'($urandom_range(0, 31));
      dz = ($urandom_range(0, 4) == 0);
      qn = $urandom_range(0, 1) == 1;
      rn = $urandom_range(0, 1) == 1;
      set_op(ts[37:0], tc[37:0], rq, rqm, td[34:0], rec, dz, draw, qn, rn);
      ref_model(ts[37:0], tc[37:0], rq, rqm, td[34:0], rec, dz, draw, qn, rn, eq, er);
      send_op();
      wait_valid(lat);
      total++; if (lat !== (dz ? 1 : 5)) begin bad++; $display("FAIL rand%0d_latency: got %0d want %0d", n, lat, dz ? 1 : 5); end
      total++; if (quotient !== eq) begin bad++; $display("FAIL rand%0d_quotient: got %h want %h", n, quotient, eq); end
      total++; if (remainder !== er) begin bad++; $display("FAIL rand%0d_remainder: got %h want %h", n, remainder, er); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      finish_op();
    end
  endtask

  task automatic test_back_to_back();
    int lat, first_acc;
    logic [31:0] eq, er;
    set_op(38'd2 << 31, '0, 32'd14, 32'd13, 35'd7 << 31, 2, 0, '0, 0, 0);
    send_op();
    first_acc = acc_cyc;
    wait_valid(lat);
    finish_op();
    set_op(38'd6 << 20, 38'd1 << 20, 32'd40, 32'd39, 35'd9 << 20, 13, 0, '0, 1, 0);
    ref_model(38'd6 << 20, 38'd1 << 20, 32'd40, 32'd39, 35'd9 << 20, 13, 0, '0, 1, 0, eq, er);
    send_op();
    total++; if (acc_cyc - first_acc !== 6) begin bad++; $display("FAIL b2b_interval: got %0d want 6", acc_cyc - first_acc); end
    wait_valid(lat);
    total++; if (quotient !== eq || remainder !== er) begin
      bad++; $display("FAIL b2b_result: got q=%h r=%h want q=%h r=%h", quotient, remainder, eq, er);
    end
    finish_op();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_correction();
    test_div_zero();
    test_signed();
    test_backpressure_reset();
    test_boundary();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/post_processing.md
# post_processing

Back end of the iterative divider: accepts the final carry-save partial remainder and the on-the-fly quotient pair (Q, QM) from the iteration stage. Resolves the remainder sign, applies the one-step correction, and undoes the normalization shift that pre-processing applied, using its `recovery` value. Applies the signed-result fixups and presents the architectural quotient/remainder to the ALU writeback with a valid/ready handshake. It is a multi-cycle FSM that holds one operation at a time.

## Interface
- `DW`, 32: operand/result width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: iteration stage has a finished operation.
- `in_ready` out 1: high only in IDLE.
- `rem_sum` in DW+6: carry-save remainder, sum vector (two's complement).
- `rem_carry` in DW+6: carry-save remainder, carry vector.
- `q` in DW: converted quotient Q.
- `qm` in DW: converted quotient Q−1.
- `divisor_star` in DW+3: normalized divisor, same scale as the remainder.
- `recovery` in DW/2: normalization position, 0..31.
- `div_zero` in 1: divisor was zero.
- `dividend_raw` in DW: unsigned dividend magnitude, used for divide-by-zero.
- `quot_neg` in 1: negate quotient (signed op, operand signs differ).
- `rem_neg` in 1: negate remainder (signed op, dividend negative).
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts.
- `quotient` out DW: final quotient.
- `remainder` out DW: final remainder.

## Operation
- FSM states: IDLE, RESOLVE, CORRECT, DENORM, SIGN, DONE.
- IDLE:
  - On `in_valid && in_ready`, register all inputs.
  - Go to DONE if `div_zero`, else RESOLVE.
- RESOLVE: `r = rem_sum + rem_carry`, mod 2^(DW+6).
- CORRECT:
  - If `r[DW+5]` is 1 (negative): `r = r + zero-extended divisor_star`, quotient register = `qm`.
  - Otherwise: quotient register = `q`.
- DENORM: remainder register = `(r >> (DW+1−recovery))[DW−1:0]`, a logical shift. The shift amount is 33 for `recovery` 0 and 2 for `recovery` 31.
- SIGN:
  - If `quot_neg`, quotient = −quotient (two's complement, DW bits).
  - If `rem_neg`, remainder = −remainder.
- Divide-by-zero path, in IDLE→DONE: quotient = all ones, remainder = `dividend_raw` negated if `rem_neg`. `quot_neg` is ignored.
- DONE:
  - `out_valid` = 1.
  - Outputs hold stable until `out_valid && out_ready`, then return to IDLE.
- Signed overflow (−2^31 / −1) is handled upstream; this block only sees magnitudes.

## Timing
- Reset (`rst_n` low at a clock edge): state = IDLE, `in_ready` = 1, `out_valid` = 0, `quotient` = 0, `remainder` = 0.
  - Reset mid-operation aborts and discards the operation.
  - No output pulse after reset.
- Normal latency: acceptance edge E0; RESOLVE/CORRECT/DENORM/SIGN occupy E1–E4.
  - `out_valid` rises in the cycle after E4, i.e. 5 cycles after acceptance.
  - Results are registered; no combinational input-to-output path.
- Divide-by-zero latency: `out_valid` in the cycle after E0.
- `in_ready` is a registered decode of IDLE. The next operation can be accepted in the cycle after the output handshake (minimum initiation interval 6 cycles).
- `out_ready` low in DONE: stall indefinitely, outputs unchanged.
- `in_valid` outside IDLE is ignored; no input is captured.

## Structure
- A shared divider package holds:
  - State encoding.
  - Width constants: `REM_W = DW+6` and `DIVS_W = DW+3`.
  - Shift base `NORM_BASE = DW+1`.
- Use those constants here and in the pre-processing stage.
- One natural sub-module: `rem_denorm_shifter`, a combinational right barrel shifter from REM_W bits down to DW bits, with 6-bit amount. It is used in DENORM.
- The FSM, correction adder and negation stay in the top level.

## Test plan
- Positive remainder, no correction:
  - Stimulus: 100/7, `recovery`=2, `rem_sum`=2<<31, `rem_carry`=0, `q`=14, `qm`=13.
  - Response: quotient 14, remainder 2, `out_valid` 5 cycles after acceptance.
- Negative remainder, correction taken:
  - Stimulus: same operands, `rem_sum`=(−5)<<31 mod 2^38, `rem_carry`=0, `q`=15, `qm`=14, `divisor_star`=7<<31.
  - Response: quotient 14, remainder 2.
- Divide by zero:
  - Stimulus: `div_zero`=1, `dividend_raw`=0x1234.
  - Response: quotient 0xFFFFFFFF, remainder 0x1234, `out_valid` 1 cycle after acceptance.
- Signed fixup: corrected result quotient 3, remainder 1, with `quot_neg`=`rem_neg`=1 (−7/2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Backpressure and reset:
  - Hold `out_ready`=0 for 10 cycles → outputs stable, `in_ready`=0, extra `in_valid` ignored.
  - Then assert `rst_n`=0 → next cycle `out_valid`=0, `in_ready`=1, outputs 0.
- Boundary shifts:
  - `recovery`=31 with remainder value 5 scaled by <<2 → remainder 5.
  - `recovery`=0 with remainder 0 (divisor 1) → quotient = `q`, remainder 0.
